i2cmb_wb_sequencer: RTL and testbench

- Hardware Wishbone master that runs complete byte-level I2C transactions on the I2CMB core through its 4-register Wishbone slave: CSR=0, DPR=1, CMDR=2, FSMR=3.
- A client issues one request (bus, address, direction, length). The sequencer performs enable, set-bus, start, address, data and stop. It waits on the core's interrupt after each command, checks the CMDR status bits, and reports one completion status.
- It sits between system-level requesters and the I2CMB Wishbone port. It replaces the testbench Wishbone driver in integrated builds.

---
 rtl/i2cmb_wb_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// i2cmb_wb_sequencer
//   Wishbone master that runs one complete byte-level I2C transaction on the
//   I2CMB core per client request: enable, set-bus, start, address, data, stop.
//   After every command write it waits for irq_i, reads CMDR back and decodes
//   the status bits. One done_o pulse with status_o reports the outcome.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_*                    classic single-cycle Wishbone master (stb == cyc)
//   irq_i                   I2CMB interrupt
//   req_*                   request handshake (bus, address, direction, length)
//   wr_data_i/valid/ready   write byte stream, one byte consumed per ready pulse
//   rd_data_o/rd_valid_o    read byte stream, no backpressure
//   done_o/status_o         completion pulse and code (OK/NAK/AL/ERR/TIMEOUT)
//   busy_o                  request in progress
`timescale 1ns/1ps
module i2cmb_wb_sequencer #(
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [1:0]       wb_adr_o,
    output logic [7:0]       wb_dat_o,
    input  logic [7:0]       wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             irq_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [3:0]       req_bus_i,
    input  logic [6:0]       req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic [2:0]       status_o,
    output logic             busy_o
);
    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;

    localparam logic [2:0] ST_OK  = 3'd0;
    localparam logic [2:0] ST_NAK = 3'd1;
    localparam logic [2:0] ST_AL  = 3'd2;
    localparam logic [2:0] ST_ERR = 3'd3;
    localparam logic [2:0] ST_TO  = 3'd4;

    typedef enum logic [4:0] {
        S_IDLE, S_EN, S_SETBUS_DPR, S_SETBUS_CMD, S_START_CMD, S_ADDR_DPR,
        S_ADDR_CMD, S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR,
        S_STOP_CMD, S_WAIT, S_RD_CMDR, S_TO_CSR, S_DONE
    } state_t;

    // Which command the shared WAIT/RD_CMDR states are currently checking.
    typedef enum logic [2:0] {
        PH_SETBUS, PH_START, PH_ADDR, PH_DATA, PH_STOP
    } phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic               enabled_q, enabled_d;
    logic               req_we_q, req_we_d;
    logic [3:0]         bus_q, bus_d;
    logic [6:0]         addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         wbyte_q, wbyte_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [2:0]         status_q, status_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wb_cyc_q, wb_cyc_d;
    logic               wb_we_q, wb_we_d;
    logic [1:0]         wb_adr_q, wb_adr_d;
    logic [7:0]         wb_dat_q, wb_dat_d;

    logic               acc_req, acc_we, acc_done;
    logic [1:0]         acc_adr;
    logic [7:0]         acc_dat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_SETBUS;
            enabled_q  <= 1'b0;
            req_we_q   <= 1'b0;
            bus_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wbyte_q    <= '0;
            to_q       <= '0;
            status_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wb_cyc_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            enabled_q  <= enabled_d;
            req_we_q   <= req_we_d;
            bus_q      <= bus_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wbyte_q    <= wbyte_d;
            to_q       <= to_d;
            status_q   <= status_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wb_cyc_q   <= wb_cyc_d;
            wb_we_q    <= wb_we_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        enabled_d  = enabled_q;
        req_we_d   = req_we_q;
        bus_d      = bus_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wbyte_d    = wbyte_q;
        to_d       = to_q;
        status_d   = status_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wb_cyc_d   = wb_cyc_q;
        wb_we_d    = wb_we_q;
        wb_adr_d   = wb_adr_q;
        wb_dat_d   = wb_dat_q;
        acc_req    = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = ADR_CSR;
        acc_dat    = 8'h00;
        acc_done   = wb_cyc_q & wb_ack_i;

        // Each access state names its register access; the common launch/
        // retire logic after the case runs it as one classic cycle, and the
        // state advances on the ack cycle.
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_we_d = req_we_i;
                    bus_d    = req_bus_i;
                    addr_d   = req_addr_i;
                    cnt_d    = req_len_i;
                    status_d = ST_OK;
                    state_d  = enabled_q ? S_SETBUS_DPR : S_EN;
                end
            end
            S_EN: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CSR; acc_dat = 8'hC0;
                if (acc_done) begin
                    enabled_d = 1'b1;
                    state_d   = S_SETBUS_DPR;
                end
            end
            S_SETBUS_DPR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR; acc_dat = {4'h0, bus_q};
                if (acc_done) state_d = S_SETBUS_CMD;
            end
            S_SETBUS_CMD: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = 8'h06;
                if (acc_done) begin to_d = '0; phase_d = PH_SETBUS; state_d = S_WAIT; end
            end
            S_START_CMD: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = 8'h04;
                if (acc_done) begin to_d = '0; phase_d = PH_START; state_d = S_WAIT; end
            end
            S_ADDR_DPR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR; acc_dat = {addr_q, ~req_we_q};
                if (acc_done) state_d = S_ADDR_CMD;
            end
            S_ADDR_CMD: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = 8'h01;
                if (acc_done) begin to_d = '0; phase_d = PH_ADDR; state_d = S_WAIT; end
            end
            S_WR_WAIT: begin
                if (wr_valid_i) begin
                    wbyte_d = wr_data_i;
                    state_d = S_WR_DPR;
                end
            end
            S_WR_DPR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR; acc_dat = wbyte_q;
                if (acc_done) state_d = S_WR_CMD;
            end
            S_WR_CMD: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = 8'h01;
                if (acc_done) begin to_d = '0; phase_d = PH_DATA; state_d = S_WAIT; end
            end
            S_RD_CMD: begin
                // Last byte is read with NAK so the slave releases the bus.
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR;
                acc_dat = (cnt_q == LEN_W'(1)) ? 8'h03 : 8'h02;
                if (acc_done) begin to_d = '0; phase_d = PH_DATA; state_d = S_WAIT; end
            end
            S_RD_DPR: begin
                acc_req = 1'b1; acc_adr = ADR_DPR;
                if (acc_done) begin
                    rd_data_d  = wb_dat_i;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    state_d    = (cnt_q == LEN_W'(1)) ? S_STOP_CMD : S_RD_CMD;
                end
            end
            S_STOP_CMD: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = 8'h05;
                if (acc_done) begin to_d = '0; phase_d = PH_STOP; state_d = S_WAIT; end
            end
            S_WAIT: begin
                if (irq_i) state_d = S_RD_CMDR;
                else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = S_TO_CSR;
                else to_d = to_q + 1'b1;
            end
            S_RD_CMDR: begin
                acc_req = 1'b1; acc_adr = ADR_CMDR;
                if (acc_done) begin
                    // Priority AL > ERR > NAK > DON; no bit set counts as ERR.
                    // A fault reported by STOP keeps the earlier status.
                    if (phase_q == PH_STOP) begin
                        state_d = S_DONE;
                    end else if (wb_dat_i[5]) begin
                        status_d = ST_AL;  state_d = S_DONE;
                    end else if (wb_dat_i[4]) begin
                        status_d = ST_ERR; state_d = S_STOP_CMD;
                    end else if (wb_dat_i[6]) begin
                        status_d = ST_NAK; state_d = S_STOP_CMD;
                    end else if (!wb_dat_i[7]) begin
                        status_d = ST_ERR; state_d = S_STOP_CMD;
                    end else begin
                        case (phase_q)
                            PH_SETBUS: state_d = S_START_CMD;
                            PH_START:  state_d = S_ADDR_DPR;
                            PH_ADDR: begin
                                if (cnt_q == '0)   state_d = S_STOP_CMD;
                                else if (req_we_q) state_d = S_WR_WAIT;
                                else               state_d = S_RD_CMD;
                            end
                            PH_DATA: begin
                                if (req_we_q) begin
                                    cnt_d   = cnt_q - 1'b1;
                                    state_d = (cnt_q == LEN_W'(1)) ? S_STOP_CMD : S_WR_WAIT;
                                end else begin
                                    state_d = S_RD_DPR;
                                end
                            end
                            default:   state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_TO_CSR: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CSR; acc_dat = 8'h00;
                if (acc_done) begin
                    enabled_d = 1'b0;
                    status_d  = ST_TO;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (acc_req && !wb_cyc_q) begin
            wb_cyc_d = 1'b1;
            wb_we_d  = acc_we;
            wb_adr_d = acc_adr;
            wb_dat_d = acc_dat;
        end
        if (acc_done) begin
            wb_cyc_d = 1'b0;
            wb_we_d  = 1'b0;
            wb_adr_d = '0;
            wb_dat_d = '0;
        end
    end

    assign wb_cyc_o    = wb_cyc_q;
    assign wb_stb_o    = wb_cyc_q;
    assign wb_we_o     = wb_we_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign req_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WR_WAIT) && wr_valid_i;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = (state_q == S_DONE);
    assign status_o    = status_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// tb_i2cmb_wb_sequencer
//   Bench for i2cmb_wb_sequencer: a behavioural I2CMB slave (register log,
//   interrupt generation, scripted CMDR status) plus a transaction-level
//   model that lists the register writes and read bytes a request must give.
`timescale 1ns/1ps
module tb_i2cmb_wb_sequencer;
    logic       clk, rst_i;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0] wb_adr_o;
    logic [7:0] wb_dat_o, wb_dat_i;
    logic       wb_ack_i, irq_i;
    logic       req_valid_i, req_ready_o, req_we_i;
    logic [3:0] req_bus_i;
    logic [6:0] req_addr_i;
    logic [7:0] req_len_i;
    logic [7:0] wr_data_i;
    logic       wr_valid_i, wr_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o, done_o, busy_o;
    logic [2:0] status_o;

    i2cmb_wb_sequencer #(.LEN_W(8), .TIMEOUT_CYCLES(100), .TO_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .irq_i(irq_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .done_o(done_o), .status_o(status_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    // ---------------- slave model state ----------------
    logic [9:0] log_q[$];       // {adr, dat} of every register write
    int         wtime[$];       // cycle number of each logged write
    logic [7:0] rd_src[$];      // bytes the slave returns on DPR reads
    logic [7:0] wr_q[$];        // bytes offered on the write stream
    logic [7:0] rd_got[$];      // bytes seen on rd_valid_o
    int         cmd_k, fault_idx, to_idx, irq_cnt, cyc_n;
    logic [7:0] fault_val, resp;
    int         done_cnt;
    logic [2:0] done_stat;
    logic       busy_at_done;
    logic       wr_pop;

    initial begin
        wb_ack_i = 0; irq_i = 0; wb_dat_i = 0; wr_valid_i = 0; wr_data_i = 0;
        cmd_k = 0; fault_idx = -1; to_idx = -1; irq_cnt = 0; cyc_n = 0;
        fault_val = 8'h80; resp = 8'h80; done_cnt = 0; done_stat = 0;
        busy_at_done = 0; wr_pop = 0;
    end

    always @(negedge clk) begin
        logic new_pop;
        cyc_n++;
        if (rst_i) begin
            wb_ack_i = 0; irq_i = 0; irq_cnt = 0; wr_pop = 0; wr_valid_i = 0;
        end else begin
            if (done_o) begin
                done_cnt++; done_stat = status_o; busy_at_done = busy_o;
            end
            if (rd_valid_o) rd_got.push_back(rd_data_o);
            new_pop = wr_ready_o && wr_valid_i;
            if (wr_pop && wr_q.size() > 0) void'(wr_q.pop_front());
            wr_pop     = new_pop;
            wr_valid_i = (wr_q.size() > 0);
            wr_data_i  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) irq_i = 1;
            end
            if (wb_ack_i) begin
                wb_ack_i = 0;
            end else if (wb_cyc_o && wb_stb_o) begin
                wb_ack_i = 1;
                if (wb_we_o) begin
                    log_q.push_back({wb_adr_o, wb_dat_o});
                    wtime.push_back(cyc_n);
                    if (wb_adr_o == 2'd2) begin
                        resp = (cmd_k == fault_idx) ? fault_val : 8'h80;
                        if (cmd_k != to_idx) irq_cnt = $urandom_range(1, 4);
                        cmd_k++;
                    end
                end else if (wb_adr_o == 2'd2) begin
                    wb_dat_i = resp; irq_i = 0;
                end else if (wb_adr_o == 2'd1) begin
                    wb_dat_i = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                end else begin
                    wb_dat_i = 8'h00;
                end
            end
        end
    end

    // ---------------- transaction-level reference ----------------
    bit         model_en = 0;
    logic [9:0] exp_log[$];
    logic [7:0] exp_rd[$];
    logic [7:0] m_wd[$];
    logic [7:0] m_rd[$];

    // Walks the command list of a request: each I2C step is an optional DPR
    // write then a CMDR write whose response decides whether to go on.
    task automatic run_model(input bit we, input logic [3:0] bus, input logic [6:0] addr,
                             input int len, input int fidx, input logic [7:0] fval,
                             input int tidx, output int st);
        int k; int nsteps; logic [7:0] r; logic [7:0] cmd;
        exp_log.delete(); exp_rd.delete();
        st = 0; k = 0;
        if (!model_en) begin exp_log.push_back({2'd0, 8'hC0}); model_en = 1; end
        nsteps = 3 + len;
        for (int s = 0; s < nsteps; s++) begin
            if (s == 0) begin exp_log.push_back({2'd1, 4'h0, bus}); cmd = 8'h06; end
            else if (s == 1) cmd = 8'h04;
            else if (s == 2) begin exp_log.push_back({2'd1, addr, ~we}); cmd = 8'h01; end
            else if (we) begin exp_log.push_back({2'd1, m_wd[s-3]}); cmd = 8'h01; end
            else cmd = (s == nsteps - 1) ? 8'h03 : 8'h02;
            exp_log.push_back({2'd2, cmd});
            if (k == tidx) begin
                exp_log.push_back({2'd0, 8'h00}); model_en = 0; st = 4; return;
            end
            r = (k == fidx) ? fval : 8'h80;
            k++;
            if (r[5]) begin st = 2; return; end
            if (r[4])  begin st = 3; break; end
            if (r[6])  begin st = 1; break; end
            if (!r[7]) begin st = 3; break; end
            if (!we && s >= 3) exp_rd.push_back(m_rd[s-3]);
        end
        exp_log.push_back({2'd2, 8'h05});
        if (k == tidx) begin
            exp_log.push_back({2'd0, 8'h00}); model_en = 0; st = 4;
        end
    endtask

    task automatic drive_req(input bit we, input logic [3:0] bus, input logic [6:0] addr,
                             input int len);
        for (int i = 0; i < 200 && !req_ready_o; i++) @(negedge clk);
        req_we_i = we; req_bus_i = bus; req_addr_i = addr; req_len_i = 8'(len);
        req_valid_i = 1;
        @(negedge clk);
        req_valid_i = 0;
    endtask

    task automatic run_req(input string nm, input bit we, input logic [3:0] bus,
                           input logic [6:0] addr, input int len, input int fidx,
                           input logic [7:0] fval, input int tidx,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input bit use_exp, input int exp_st);
        int st_m; int bad;
        m_wd.delete(); m_rd.delete();
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = (i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : 8'($urandom);
            if (we) m_wd.push_back(b); else m_rd.push_back(b);
        end
        wr_q = m_wd; rd_src = m_rd;
        log_q.delete(); wtime.delete(); rd_got.delete();
        cmd_k = 0; fault_idx = fidx; fault_val = fval; to_idx = tidx; done_cnt = 0;
        run_model(we, bus, addr, len, fidx, fval, tidx, st_m);
        drive_req(we, bus, addr, len);
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({nm, " done_pulses"}, done_cnt, 1);
        chk({nm, " status"}, done_stat, use_exp ? exp_st : st_m);
        chk({nm, " busy_at_done"}, busy_at_done, 0);
        bad = (log_q.size() == exp_log.size()) ? -1 : 1000 + log_q.size();
        for (int i = 0; i < log_q.size() && i < exp_log.size() && bad < 0; i++)
            if (log_q[i] !== exp_log[i]) bad = i;
        if (bad >= 0)
            for (int i = 0; i < log_q.size(); i++) $display("  %s write %0d = %h", nm, i, log_q[i]);
        chk({nm, " wlog_mismatch_idx"}, bad, -1);
        bad = (rd_got.size() == exp_rd.size()) ? -1 : 1000 + rd_got.size();
        for (int i = 0; i < rd_got.size() && i < exp_rd.size() && bad < 0; i++)
            if (rd_got[i] !== exp_rd[i]) bad = i;
        chk({nm, " rd_mismatch_idx"}, bad, -1);
    endtask

    typedef struct {
        bit         we;
        logic [3:0] bus;
        logic [6:0] addr;
        int         len;
        int         fidx;
        logic [7:0] fval;
        int         tidx;
        logic [7:0] d0, d1, d2;
        int         exp_st;
    } vec_t;

    vec_t tbl[9];
    logic [7:0] fvals[5];

    initial begin
        int si, ti, gap, csr_n;
        tbl[0] = '{1'b1, 4'd3, 7'h22, 2, -1, 8'h80, -1, 8'hAA, 8'h55, 8'h00, 0};
        tbl[1] = '{1'b0, 4'd0, 7'h50, 3, -1, 8'h80, -1, 8'h11, 8'h22, 8'h33, 0};
        tbl[2] = '{1'b1, 4'd1, 7'h3A, 2,  2, 8'hC0, -1, 8'h01, 8'h02, 8'h03, 1};
        tbl[3] = '{1'b0, 4'd2, 7'h10, 1,  1, 8'hA0, -1, 8'h44, 8'h00, 8'h00, 2};
        tbl[4] = '{1'b1, 4'd5, 7'h7F, 3,  3, 8'h90, -1, 8'h10, 8'h20, 8'h30, 3};
        tbl[5] = '{1'b0, 4'd7, 7'h01, 2,  0, 8'h00, -1, 8'h66, 8'h77, 8'h00, 3};
        tbl[6] = '{1'b1, 4'd0, 7'h2C, 0, -1, 8'h80, -1, 8'h00, 8'h00, 8'h00, 0};
        tbl[7] = '{1'b1, 4'd9, 7'h2D, 0,  3, 8'h40, -1, 8'h00, 8'h00, 8'h00, 0};
        tbl[8] = '{1'b0, 4'd4, 7'h61, 4,  4, 8'hC0, -1, 8'h5A, 8'hA5, 8'h3C, 1};
        fvals[0] = 8'hC0; fvals[1] = 8'hA0; fvals[2] = 8'h90; fvals[3] = 8'h00; fvals[4] = 8'h84;

        rst_i = 1; req_valid_i = 0; req_we_i = 0; req_bus_i = 0; req_addr_i = 0; req_len_i = 0;
        repeat (3) @(negedge clk);
        chk("rst wb_cyc", wb_cyc_o, 0);
        chk("rst wb_stb", wb_stb_o, 0);
        chk("rst wb_we", wb_we_o, 0);
        chk("rst wb_adr", wb_adr_o, 0);
        chk("rst wb_dat", wb_dat_o, 0);
        chk("rst req_ready", req_ready_o, 1);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst rd_valid", rd_valid_o, 0);
        chk("rst wr_ready", wr_ready_o, 0);
        chk("rst status", status_o, 0);
        rst_i = 0;
        repeat (2) @(negedge clk);

        // Directed vectors with fixed expected status.
        foreach (tbl[i])
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].bus, tbl[i].addr, tbl[i].len,
                    tbl[i].fidx, tbl[i].fval, tbl[i].tidx, tbl[i].d0, tbl[i].d1, tbl[i].d2,
                    1'b1, tbl[i].exp_st);

        // Read after an enabled core must not re-enable it.
        run_req("rd_noen", 1'b0, 4'd2, 7'h50, 3, -1, 8'h80, -1, 8'h11, 8'h22, 8'h33, 1'b1, 0);
        csr_n = 0;
        foreach (log_q[i]) if (log_q[i][9:8] == 2'd0) csr_n++;
        chk("rd_noen csr_writes", csr_n, 0);

        // Timeout: irq never comes after START.
        run_req("timeout", 1'b1, 4'd3, 7'h22, 1, -1, 8'h80, 1, 8'h99, 8'h00, 8'h00, 1'b1, 4);
        si = -1; ti = -1;
        foreach (log_q[i]) begin
            if (log_q[i] == {2'd2, 8'h04} && si < 0) si = i;
            if (log_q[i] == {2'd0, 8'h00} && ti < 0) ti = i;
        end
        gap = (si >= 0 && ti >= 0) ? wtime[ti] - wtime[si] : -1;
        if (gap < 100 || gap > 104) $display("  timeout gap = %0d cycles", gap);
        chk("timeout gap_in_100_104", (gap >= 100 && gap <= 104) ? 1 : 0, 1);
        run_req("after_to", 1'b1, 4'd3, 7'h22, 1, -1, 8'h80, -1, 8'h42, 8'h00, 8'h00, 1'b1, 0);
        chk("after_to first_write", (log_q.size() > 0) ? int'(log_q[0]) : -1, int'({2'd0, 8'hC0}));

        // Asynchronous reset while a Wishbone cycle is open.
        log_q.delete(); rd_got.delete(); wr_q.delete(); wr_q.push_back(8'h12); wr_q.push_back(8'h34);
        cmd_k = 0; fault_idx = -1; to_idx = -1; done_cnt = 0;
        drive_req(1'b1, 4'd1, 7'h33, 2);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (wb_cyc_o) break;
        end
        chk("arst cyc_seen", wb_cyc_o, 1);
        #1 rst_i = 1;
        #1;
        chk("arst cyc_async", wb_cyc_o, 0);
        chk("arst stb_async", wb_stb_o, 0);
        repeat (2) @(negedge clk);
        rst_i = 0;
        repeat (5) @(negedge clk);
        chk("arst no_done", done_cnt, 0);
        chk("arst ready", req_ready_o, 1);
        model_en = 0;
        run_req("after_rst", 1'b1, 4'd1, 7'h33, 2, -1, 8'h80, -1, 8'h12, 8'h34, 8'h00, 1'b0, 0);
        chk("after_rst first_write", (log_q.size() > 0) ? int'(log_q[0]) : -1, int'({2'd0, 8'hC0}));

        // Randomized requests against the reference.
        for (int n = 0; n < 24; n++) begin
            bit we; int len, fidx, tidx;
            we = 1'($urandom);
            len = $urandom_range(0, 4);
            fidx = -1; tidx = -1;
            if ($urandom_range(0, 3) == 0) fidx = $urandom_range(0, len + 3);
            if ($urandom_range(0, 9) == 0) tidx = $urandom_range(0, len + 3);
            run_req($sformatf("rnd%0d", n), we, 4'($urandom), 7'($urandom), len, fidx,
                    fvals[$urandom_range(0, 4)], tidx, 8'($urandom), 8'($urandom),
                    8'($urandom), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
